// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into 32-bit words and streams
// each {word, byte address} through a 2-entry output buffer until DEPTH_WORDS
// words have been issued.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [19:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [31:0] out_addr,
    output logic [15:0] words_issued,
    output logic        full,
    output logic        err
);

    localparam logic [16:0] DepthW = 17'(DEPTH_WORDS);

    typedef enum logic [0:0] {StLoad, StFull} state_e;

    state_e      state_q, state_d;
    logic [31:0] head_word_q, head_addr_q;
    logic [31:0] tail_word_q, tail_addr_q;
    logic [1:0]  cnt_q;
    logic [15:0] issued_q;
    logic        err_q;

    logic [31:0] enc_word;
    logic [31:0] new_addr;
    logic        fmt_ok;
    logic        accept;
    logic        push;
    logic        pop;
    logic        last;

    // Field packing; the bit placement mirrors the decoder's extraction exactly.
    always_comb begin
        enc_word = 32'h0;
        fmt_ok   = 1'b1;
        unique case (in_fmt)
            3'd0: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            3'd1: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
            3'd2: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
            // B uses the raw S-style split, not the architectural scrambled layout.
            3'd3: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b1100111};
            3'd4: enc_word = {in_imm, in_rd, 7'b1101111};
            3'd5: enc_word = {in_imm, in_rd, 7'b0110111};
            default: fmt_ok = 1'b0;
        endcase
    end

    // Handshake decode and next-state; restart blocks acceptance and pops.
    always_comb begin
        in_ready = (state_q == StLoad) && (cnt_q < 2'd2) && !restart;
        accept   = in_valid && in_ready;
        push     = accept && fmt_ok;
        pop      = (cnt_q != 2'd0) && out_ready && !restart;
        new_addr = BASE_ADDR + {14'd0, issued_q, 2'b00};
        last     = push && (({1'b0, issued_q} + 17'd1) == DepthW);
        state_d  = state_q;
        if (restart) begin
            state_d = StLoad;
        end else if (state_q == StLoad && last) begin
            state_d = StFull;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StLoad;
        end else begin
            state_q <= state_d;
        end
    end

    // Output buffer: head always in the head slot; a pop shifts tail into head.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            head_word_q <= 32'h0;
            head_addr_q <= 32'h0;
            tail_word_q <= 32'h0;
            tail_addr_q <= 32'h0;
            cnt_q       <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        head_word_q <= enc_word;
                        head_addr_q <= new_addr;
                    end else begin
                        tail_word_q <= enc_word;
                        tail_addr_q <= new_addr;
                    end
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_word_q <= tail_word_q;
                    head_addr_q <= tail_addr_q;
                    cnt_q       <= cnt_q - 2'd1;
                end
                // Push+pop only happens with one entry held (in_ready is low at two).
                2'b11: begin
                    head_word_q <= enc_word;
                    head_addr_q <= new_addr;
                end
                default: ;
            endcase
        end
    end

    // Issue counter and sticky invalid-format flag.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            issued_q <= 16'd0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                issued_q <= issued_q + 16'd1;
            end
            if (accept && !fmt_ok) begin
                err_q <= 1'b1;
            end
        end
    end

    assign out_valid    = (cnt_q != 2'd0);
    assign out_word     = out_valid ? head_word_q : 32'h0;
    assign out_addr     = out_valid ? head_addr_q : 32'h0;
    assign words_issued = issued_q;
    assign full         = (state_q == StFull);
    assign err          = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized stimulus against a queue-based
// reference model of the encoder, buffer, counters and flags.
module tb_instr_encoder;

    localparam logic [31:0] Base  = 32'h0000_0000;
    localparam int unsigned Depth = 4;

    logic        clk = 1'b0;
    logic        rst, restart, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  in_fmt, in_funct3;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [6:0]  in_funct7;
    logic [19:0] in_imm;
    logic [31:0] out_word, out_addr;
    logic [15:0] words_issued;
    logic        full, err;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state.
    logic [63:0] mq[$];
    int unsigned m_issued = 0;
    bit          m_full = 0;
    bit          m_err = 0;

    always #5 clk = ~clk;

    instr_encoder #(
        .BASE_ADDR  (Base),
        .DEPTH_WORDS(Depth)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .restart     (restart),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_fmt      (in_fmt),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_funct3   (in_funct3),
        .in_funct7   (in_funct7),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_word    (out_word),
        .out_addr    (out_addr),
        .words_issued(words_issued),
        .full        (full),
        .err         (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Arithmetic description of the instruction layouts.
    function automatic int unsigned ref_enc(input int unsigned fmt, rd, rs1, rs2, f3, f7, imm);
        int unsigned w;
        case (fmt)
            0: w = 51  + rd * 128 + f3 * 4096 + rs1 * 32768 + rs2 * 1048576 + f7 * 33554432;
            1: w = 19  + rd * 128 + f3 * 4096 + rs1 * 32768 + (imm % 4096) * 1048576;
            2, 3: w = ((fmt == 2) ? 35 : 103) + (imm % 32) * 128 + f3 * 4096 + rs1 * 32768
                      + rs2 * 1048576 + ((imm / 32) % 128) * 33554432;
            4: w = 111 + rd * 128 + imm * 4096;
            default: w = 55 + rd * 128 + imm * 4096;
        endcase
        return w;
    endfunction

    // Check every output against the model, then advance one clock and the model.
    task automatic tick();
        bit          acc;
        logic [31:0] w, a;
        #1;
        check("in_ready", 32'(in_ready), 32'(!m_full && mq.size() < 2 && !restart));
        check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        check("out_word", out_word, (mq.size() > 0) ? mq[0][63:32] : 32'h0);
        check("out_addr", out_addr, (mq.size() > 0) ? mq[0][31:0] : 32'h0);
        check("words_issued", 32'(words_issued), m_issued);
        check("full", 32'(full), 32'(m_full));
        check("err", 32'(err), 32'(m_err));
        if (rst || restart) begin
            mq.delete();
            m_issued = 0;
            m_full   = 0;
            m_err    = 0;
        end else begin
            acc = in_valid && !m_full && mq.size() < 2;
            if (out_ready && mq.size() > 0) void'(mq.pop_front());
            if (acc) begin
                if (in_fmt <= 3'd5) begin
                    w = ref_enc(in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
                    a = Base + 4 * m_issued;
                    mq.push_back({w, a});
                    m_issued++;
                    if (m_issued == Depth) m_full = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] f, input logic [4:0] rd,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [19:0] imm);
        in_valid  = v;
        in_fmt    = f;
        in_rd     = rd;
        in_rs1    = r1;
        in_rs2    = r2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
    endtask

    task automatic do_restart();
        in_valid = 1'b0;
        restart  = 1'b1;
        tick();
        restart  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        restart = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 20'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        tick();

        // R-type, held in the buffer.
        drive(1'b1, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 20'd0);
        tick();
        in_valid = 1'b0;
        check("r_word", out_word, 32'h002081B3);
        check("r_addr", out_addr, 32'h0);
        out_ready = 1'b1;
        tick();

        // I, U, B back to back after restart.
        do_restart();
        drive(1'b1, 3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 20'h00FFF);
        tick();
        check("i_word", out_word, 32'hFFF00293);
        check("i_addr", out_addr, 32'h0);
        drive(1'b1, 3'd5, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 20'h12345);
        tick();
        check("u_word", out_word, 32'h12345537);
        check("u_addr", out_addr, 32'h4);
        drive(1'b1, 3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 20'h00010);
        tick();
        check("b_word", out_word, 32'h00208867);
        check("b_addr", out_addr, 32'h8);
        in_valid = 1'b0;
        tick();

        // Backpressure: two accepted, third stalls until drain.
        do_restart();
        out_ready = 1'b0;
        drive(1'b1, 3'd2, 5'd7, 5'd4, 5'd9, 3'd2, 7'd0, 20'h00ABC);
        tick();
        drive(1'b1, 3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 20'hFEDCB);
        tick();
        drive(1'b1, 3'd0, 5'd31, 5'd30, 5'd29, 3'd7, 7'h7F, 20'd0);
        tick();
        check("bp_ready_low", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        repeat (2) tick();

        // Depth limit: five offered, four accepted, then restart.
        do_restart();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'd1, 5'(i), 5'(i + 1), 5'd0, 3'd1, 7'd0, 20'(i * 3));
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("depth_full", 32'(full), 32'h1);
        check("depth_count", 32'(words_issued), 32'd4);
        do_restart();
        drive(1'b1, 3'd5, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 20'h00001);
        tick();
        in_valid = 1'b0;
        check("restart_addr", out_addr, Base);
        tick();

        // Invalid format between two valid words.
        do_restart();
        drive(1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 3'd4, 7'h20, 20'd0);
        tick();
        drive(1'b1, 3'd7, 5'd1, 5'd2, 5'd3, 3'd4, 7'h20, 20'hFFFFF);
        tick();
        drive(1'b1, 3'd1, 5'd6, 5'd7, 5'd0, 3'd0, 7'd0, 20'h00123);
        tick();
        in_valid = 1'b0;
        tick();
        check("inv_err", 32'(err), 32'h1);
        check("inv_count", 32'(words_issued), 32'd2);

        // Restart with two held and a valid input pending; err must clear.
        out_ready = 1'b0;
        do_restart();
        drive(1'b1, 3'd6, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 20'd0);
        tick();
        drive(1'b1, 3'd0, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 20'd0);
        repeat (2) tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        in_valid = 1'b0;
        check("rs_valid", 32'(out_valid), 32'h0);
        check("rs_err", 32'(err), 32'h0);
        tick();

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            drive(1'($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5)),
                  5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
                  20'($urandom));
            out_ready = 1'($urandom_range(0, 9) < 6);
            restart = m_full ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 49) == 0);
            tick();
        end
        restart = 1'b0;
        in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Field-to-word instruction encoder: the write-side counterpart of the core's instruction-field decoder. It accepts decoded fields (format, registers, functs, immediate) over a valid/ready handshake, packs them into 32-bit instruction words using the same bit placement the decoder extracts, and streams each word with its instruction-memory byte address through a 2-entry output buffer. It sits between the testbench/boot program loader and the instruction memory write port, and round-trips exactly with the decoder.

## Interface

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address assigned to the first word after reset/restart.
- DEPTH_WORDS, 256: number of words issued before the block stops accepting; 1..65535.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- restart  in  1  synchronous flush: clears buffer, address, count and err.
- in_valid  in  1  field set present.
- in_ready  out  1  block can accept this cycle.
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=J, 5=U, 6/7 invalid.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3; in_funct7  in  7.
- in_imm  in  20  immediate; low 12 bits used for I/S/B, all 20 for J/U.
- out_valid  out  1  buffered word available.
- out_ready  in  1  consumer takes word.
- out_word  out  32  encoded instruction.
- out_addr  out  32  byte address of out_word.
- words_issued  out  16  words accepted since reset/restart.
- full  out  1  DEPTH_WORDS words accepted.
- err  out  1  sticky: invalid format seen.

## Operation

- Opcodes: R 0110011, I 0010011, S 0100011, B 1100111, J 1101111, U 0110111 in [6:0].
- R: [31:25]=funct7, [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=rd.
- I: [31:20]=imm[11:0], rs1, funct3, rd.
- S and B: [31:25]=imm[11:5], rs2, rs1, funct3, [11:7]=imm[4:0] (raw split, no B-scrambling; matches decoder).
- J and U: [31:12]=imm[19:0], [11:7]=rd.
- Fields unused by a format are ignored; no inputs leak into other bits.
- Address: out_addr = BASE_ADDR + 4*index, index = words_issued at acceptance; 32-bit wrap-around.
- States: LOAD (accepting) and FULL. LOAD->FULL when the accepted word makes words_issued == DEPTH_WORDS. FULL->LOAD only on restart or rst. Buffer keeps draining in FULL.
- in_ready = (state==LOAD) && buffer count < 2 && !restart.
- Invalid fmt: handshake completes, nothing buffered, no address/count consumed, err set (sticky).
- Output buffer: 2-entry FIFO of {word, addr}; order preserved; out_word/out_addr are head entry, stable while out_valid && !out_ready.

## Timing

- Reset (rst or restart): in_ready per rule above (1 after reset if not restarting), out_valid=0, out_word=0, out_addr=0, words_issued=0, full=0, err=0, state LOAD, buffer empty.
- rst has priority over restart; restart has priority over any handshake the same cycle (input not accepted, output pop discarded).
- Latency: word accepted at edge N is on out_word with out_valid=1 after edge N (visible cycle N+1) if buffer was empty.
- Throughput 1 word/cycle with out_ready held high; simultaneous push and pop with 2 entries held not allowed (in_ready already 0); push+pop with 1 entry keeps count 1.
- full asserts the cycle after the last accepted word; in_ready low from that cycle.
- words_issued, err, full update on the accepting edge.

## Test plan

- R fmt=0 rd=3 rs1=1 rs2=2 f3=0 f7=0 -> out_word 0x002081B3, out_addr 0x0 one cycle later.
- I fmt=1 rd=5 rs1=0 imm=0xFFF; then U fmt=5 rd=10 imm=0x12345; then B fmt=3 rs1=1 rs2=2 imm=0x010 -> 0xFFF00293 @0x0, 0x12345537 @0x4, 0x00208867 @0x8; each round-trips through the decoder.
- out_ready=0, 3 back-to-back valid inputs -> 2 accepted, in_ready=0 on third; release -> words drain in order, third accepted.
- DEPTH_WORDS=4: 5 inputs -> 4 accepted (addr 0x0..0xC), full=1, in_ready=0; restart -> LOAD, count 0, next word @BASE_ADDR.
- fmt=7 between two valid words -> err=1, only 2 words out at consecutive addresses, words_issued=2.
- restart asserted with in_valid=1 and buffer holding 2 -> no accept, out_valid=0 next cycle, err cleared.
